filter_bank: RTL and testbench
==============================

Name: filter_bank

Overview:
- N-channel, time-multiplexed, first-order fixed-point low-pass filter for emulation.
- Generalises the single fixed filter to N channels, each with a runtime-writable coefficient, enable, and saturation/overrun status.
- One shared multiply-accumulate datapath; one channel is updated per clock after each `step` strobe.
- Sits between per-channel analog-model inputs and the probed outputs of the emulation top.

Parameters:
N_CH, 4, number of channels (1..16)
W, 16, signed width of each input/output sample
COEF_W, 16, unsigned coefficient width
COEF_FRAC, 14, fractional bits of coefficient (alpha range [0, 2^(COEF_W-COEF_FRAC)))
COEF_RST, 16'h0400, reset value of every channel coefficient

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
step  input  1  one-cycle request for one filter time step on all enabled channels
v_in  input  N_CH*W  packed signed inputs, channel i at [i*W +: W]
chan_en  input  N_CH  per-channel update enable, sampled with v_in
coef_we  input  1  coefficient write strobe
coef_addr  input  $clog2(N_CH) (min 1)  coefficient channel index
coef_wdata  input  COEF_W  coefficient value
sat_clr  input  1  clears sat_flag and overrun
v_out  output  N_CH*W  packed signed filter states, registered
busy  output  1  high while a step is in progress
done  output  1  one-cycle pulse when the step completes
sat_flag  output  N_CH  sticky per-channel saturation indication
overrun  output  1  sticky: step arrived while busy

Behaviour:
- Reset (async assert, sync release): v_out=0, coefs=COEF_RST, busy=0, done=0, sat_flag=0, overrun=0, FSM=IDLE, idx=0. Reset mid-step aborts the step; no partial results are retained.
- FSM IDLE -> CALC -> DONE -> IDLE.
- IDLE: step=1 at edge E0 snapshots v_in and chan_en, sets idx=0, enters CALC. busy is high from E0 through the DONE cycle.
- CALC: edge E0+1+i writes channel i, for i=0..N_CH-1. After writing N_CH-1 the FSM enters DONE. A step takes N_CH+1 cycles.
- DONE: done=1 for exactly one cycle, then IDLE. A step arriving in the DONE cycle is treated as overrun, not accepted.
- Step while busy (CALC or DONE): ignored; overrun set.
- Update for channel i: d = x - y (W+1 bits); p = d*alpha (signed, W+COEF_W+2 bits); s = p >>> COEF_FRAC (arithmetic, floor); r = y + s.
- Saturation: r is clamped to [-2^(W-1), 2^(W-1)-1]. When clamped, sat_flag[i] is set.
- chan_en snapshot bit 0: v_out[i] holds; slot time is still consumed, so latency does not change.
- Coefficient write: applies at the edge, at any time. If the write targets the channel computed in the same cycle, that computation uses the old value.
- sat_clr: clears flags. A simultaneous set wins over clear.
- v_out changes only at CALC edges. Other channels remain stable.

Decomposition:
- Package filter_bank_pkg holds:
  - fsm state enum (IDLE/CALC/DONE)
  - localparams for product and sum widths
  - the saturation function `sat_w`
- Sub-module fb_datapath: combinational update of y, x, alpha producing r and a sat bit. Its own unit test drives it exhaustively with small W.

Test Plan:
1. N_CH=4, alpha=0x2000 (0.5) on all channels, v_in ch0=1000, three steps -> ch0 500, 750, 875. done pulses at E0+5 each step; busy for 5 cycles.
2. x=-1, y=0, alpha=0.5 -> y=-1 (floor); then x=0 -> y=-1+floor(0.5)=-1. Confirms rounding toward -inf.
3. alpha=0x8000 (2.0), x=20000, y=0 -> v_out=32767 and sat_flag[ch]=1. sat_clr -> 0. Repeat with x=-20000 -> -32768.
4. chan_en=4'b1010 -> ch0 and ch2 unchanged, ch1 and ch3 updated at E0+2 and E0+4; done still at E0+5.
5. step asserted at E0+2 and again during DONE -> both ignored, overrun=1, results identical to a single step.
6. Write ch1 coef during the CALC cycle for ch1 -> old coef used this step, new coef next step. rst_n pulsed mid-CALC -> all outputs 0, busy 0 immediately.

Source files
------------

// File: rtl/filter_bank_pkg.sv
// rtl/filter_bank_pkg.sv - shared types, widths and saturation helper for filter_bank
package filter_bank_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} fb_state_t;

  localparam int FB_W       = 16;
  localparam int FB_COEF_W  = 16;
  localparam int FB_FRAC    = 14;
  localparam int FB_PROD_W  = FB_W + FB_COEF_W + 2;
  localparam int FB_SUM_W   = FB_PROD_W + 1;
  localparam int FB_WIDE_W  = 64;

  // Clamp a wide signed value to the range of a w-bit signed sample.
  function automatic logic signed [FB_WIDE_W-1:0] sat_w(input logic signed [FB_WIDE_W-1:0] v,
                                                        input int w);
    logic signed [FB_WIDE_W-1:0] hi;
    logic signed [FB_WIDE_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/fb_datapath.sv
// rtl/fb_datapath.sv - combinational first-order low-pass update for one channel
module fb_datapath
  import filter_bank_pkg::*;
#(
  parameter int W         = FB_W,
  parameter int COEF_W    = FB_COEF_W,
  parameter int COEF_FRAC = FB_FRAC
) (
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] x,
  input  logic [COEF_W-1:0]   alpha,
  output logic signed [W-1:0] r,
  output logic                sat
);

  localparam int PW = W + COEF_W + 2;
  localparam int SW = PW + 1;

  logic signed [W:0]           d;
  logic signed [PW-1:0]        de;
  logic signed [PW-1:0]        ae;
  logic signed [PW-1:0]        p;
  logic signed [PW-1:0]        s;
  logic signed [SW-1:0]        sum;
  logic signed [FB_WIDE_W-1:0] sum_wide;
  logic signed [FB_WIDE_W-1:0] clamped;

  always_comb begin
    d        = {x[W-1], x} - {y[W-1], y};
    de       = {{(PW-W-1){d[W]}}, d};
    ae       = {{(PW-COEF_W){1'b0}}, alpha};
    p        = de * ae;
    // Arithmetic shift floors toward -inf, so small negative steps still move y.
    s        = p >>> COEF_FRAC;
    sum      = {{(SW-W){y[W-1]}}, y} + {s[PW-1], s};
    sum_wide = {{(FB_WIDE_W-SW){sum[SW-1]}}, sum};
    clamped  = sat_w(sum_wide, W);
    r        = clamped[W-1:0];
    sat      = (clamped != sum_wide);
  end

endmodule

// File: rtl/filter_bank.sv
// rtl/filter_bank.sv - N-channel time-multiplexed low-pass filter with one shared update datapath
module filter_bank
  import filter_bank_pkg::*;
#(
  parameter int              N_CH      = 4,
  parameter int              W         = FB_W,
  parameter int              COEF_W    = FB_COEF_W,
  parameter int              COEF_FRAC = FB_FRAC,
  parameter logic [COEF_W-1:0] COEF_RST = 16'h0400,
  localparam int             AW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step,
  input  logic [N_CH*W-1:0]   v_in,
  input  logic [N_CH-1:0]     chan_en,
  input  logic                coef_we,
  input  logic [AW-1:0]       coef_addr,
  input  logic [COEF_W-1:0]   coef_wdata,
  input  logic                sat_clr,
  output logic [N_CH*W-1:0]   v_out,
  output logic                busy,
  output logic                done,
  output logic [N_CH-1:0]     sat_flag,
  output logic                overrun
);

  fb_state_t           state;
  logic [AW-1:0]       idx;
  logic [N_CH*W-1:0]   x_snap;
  logic [N_CH-1:0]     en_snap;
  logic [COEF_W-1:0]   coef [N_CH];

  logic signed [W-1:0] dp_y;
  logic signed [W-1:0] dp_x;
  logic signed [W-1:0] dp_r;
  logic [COEF_W-1:0]   dp_alpha;
  logic                dp_sat;
  logic                last;
  logic [N_CH-1:0]     sat_set;

  always_comb begin
    dp_y     = v_out[int'(idx)*W +: W];
    dp_x     = x_snap[int'(idx)*W +: W];
    dp_alpha = coef[idx];
    last     = (int'(idx) == N_CH - 1);
    sat_set  = '0;
    if (state == CALC && en_snap[idx] && dp_sat) sat_set[idx] = 1'b1;
  end

  fb_datapath #(.W(W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC)) u_dp (
    .y     (dp_y),
    .x     (dp_x),
    .alpha (dp_alpha),
    .r     (dp_r),
    .sat   (dp_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      x_snap   <= '0;
      en_snap  <= '0;
      v_out    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat_flag <= '0;
      overrun  <= 1'b0;
      for (int i = 0; i < N_CH; i++) coef[i] <= COEF_RST;
    end else begin
      // The datapath reads coef combinationally, so a same-cycle write lands after use.
      if (coef_we && int'(coef_addr) < N_CH) coef[coef_addr] <= coef_wdata;

      sat_flag <= (sat_clr ? '0 : sat_flag) | sat_set;
      if (step && state != IDLE) overrun <= 1'b1;
      else if (sat_clr)          overrun <= 1'b0;

      done <= 1'b0;
      case (state)
        IDLE: begin
          if (step) begin
            x_snap  <= v_in;
            en_snap <= chan_en;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (en_snap[idx]) v_out[int'(idx)*W +: W] <= dp_r;
          if (last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_bank.sv
// tb/tb_filter_bank.sv - directed table-driven bench for filter_bank
module tb_filter_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic [63:0] v_in = '0;
  logic [3:0]  chan_en = '0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic        sat_clr = 1'b0;
  logic [63:0] v_out;
  logic        busy;
  logic        done;
  logic [3:0]  sat_flag;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  logic [63:0] snap [6];
  logic [5:0]  busy_obs;
  logic [5:0]  done_obs;

  typedef struct {
    logic [15:0] coef;
    logic [63:0] vin;
    logic [3:0]  en;
    logic [63:0] vexp;
    logic [3:0]  sexp;
  } vec_t;

  vec_t tbl [9];

  filter_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .v_in       (v_in),
    .chan_en    (chan_en),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .sat_clr    (sat_clr),
    .v_out      (v_out),
    .busy       (busy),
    .done       (done),
    .sat_flag   (sat_flag),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input int c3, input int c2, input int c1, input int c0);
    return {c3[15:0], c2[15:0], c1[15:0], c0[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic write_coef(input logic [1:0] ch, input logic [15:0] val);
    coef_addr  = ch;
    coef_wdata = val;
    coef_we    = 1'b1;
    @(posedge clk); #1;
    coef_we    = 1'b0;
  endtask

  task automatic write_all(input logic [15:0] val);
    for (int c = 0; c < 4; c++) write_coef(2'(c), val);
  endtask

  task automatic pulse_clr();
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
  endtask

  // Observation k is taken 1ns after edge E0+k; mask[k] holds step high into edge E0+k.
  task automatic run_step(input logic [63:0] vin, input logic [3:0] en, input logic [5:0] mask,
                          input int ck, input logic [1:0] cch, input logic [15:0] cval);
    v_in    = vin;
    chan_en = en;
    step    = 1'b1;
    @(posedge clk); #1;
    snap[0] = v_out; busy_obs[0] = busy; done_obs[0] = done;
    for (int k = 1; k < 6; k++) begin
      step = mask[k];
      if (k == ck) begin
        coef_addr = cch; coef_wdata = cval; coef_we = 1'b1;
      end
      @(posedge clk); #1;
      coef_we = 1'b0;
      snap[k] = v_out; busy_obs[k] = busy; done_obs[k] = done;
    end
    step = 1'b0;
  endtask

  initial begin
    tbl[0] = '{16'h2000, pk(0, 0, 0, 1000),      4'hF,    pk(0, 0, 0, 500),         4'b0000};
    tbl[1] = '{16'h2000, pk(0, 0, 0, 1000),      4'hF,    pk(0, 0, 0, 750),         4'b0000};
    tbl[2] = '{16'h2000, pk(0, 0, 0, 1000),      4'hF,    pk(0, 0, 0, 875),         4'b0000};
    tbl[3] = '{16'h2000, pk(0, 0, -1, 875),      4'hF,    pk(0, 0, -1, 875),        4'b0000};
    tbl[4] = '{16'h2000, pk(0, 0, 0, 875),       4'hF,    pk(0, 0, -1, 875),        4'b0000};
    tbl[5] = '{16'h2000, pk(100, 200, 300, 400), 4'b1010, pk(50, 0, 149, 875),      4'b0000};
    tbl[6] = '{16'h8000, pk(0, 0, 0, 20000),     4'hF,    pk(-50, 0, -149, 32767),  4'b0001};
    tbl[7] = '{16'h8000, pk(0, 0, 0, -20000),    4'hF,    pk(50, 0, 149, -32768),   4'b0001};
    tbl[8] = '{16'h4000, pk(1, 2, 3, 4),         4'hF,    pk(1, 2, 3, 4),           4'b0000};

    #12;
    chk("reset_vout", v_out, 64'h0);
    chk("reset_flags", {59'h0, busy, done, overrun, sat_flag[1:0]}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      write_all(tbl[i].coef);
      pulse_clr();
      run_step(tbl[i].vin, tbl[i].en, 6'b0, 0, 2'd0, 16'h0);
      chk($sformatf("vec%0d_vout", i), snap[5], tbl[i].vexp);
      chk($sformatf("vec%0d_sat", i), {60'h0, sat_flag}, {60'h0, tbl[i].sexp});
      chk($sformatf("vec%0d_busy", i), {58'h0, busy_obs}, 64'h1F);
      chk($sformatf("vec%0d_done", i), {58'h0, done_obs}, 64'h10);
      if (i == 5) begin
        chk("en_ch1_before", {48'h0, snap[1][31:16]}, 64'hFFFF);
        chk("en_ch1_at_e2",  {48'h0, snap[2][31:16]}, 64'd149);
        chk("en_ch3_before", {48'h0, snap[3][63:48]}, 64'd0);
        chk("en_ch3_at_e4",  {48'h0, snap[4][63:48]}, 64'd50);
      end
      if (tbl[i].sexp != 4'b0000) begin
        pulse_clr();
        chk($sformatf("vec%0d_satclr", i), {60'h0, sat_flag}, 64'h0);
      end
    end

    // Extra step pulses at E0+2 and in the DONE cycle must be ignored.
    write_all(16'h2000);
    pulse_clr();
    chk("overrun_pre", {63'h0, overrun}, 64'h0);
    run_step(pk(100, 100, 100, 100), 4'hF, 6'b100100, 0, 2'd0, 16'h0);
    chk("ovr_vout", snap[5], pk(50, 51, 51, 52));
    chk("ovr_busy", {58'h0, busy_obs}, 64'h1F);
    chk("ovr_done", {58'h0, done_obs}, 64'h10);
    chk("ovr_flag", {63'h0, overrun}, 64'h1);
    @(posedge clk); #1;
    chk("ovr_no_restart", {62'h0, busy, done}, 64'h0);
    pulse_clr();
    chk("ovr_clr", {63'h0, overrun}, 64'h0);

    // ch1 coefficient rewritten on the edge that computes ch1.
    run_step(pk(50, 51, 1051, 52), 4'hF, 6'b0, 2, 2'd1, 16'h4000);
    chk("coef_old_used", snap[5], pk(50, 51, 551, 52));
    run_step(pk(50, 51, 1051, 52), 4'hF, 6'b0, 0, 2'd0, 16'h0);
    chk("coef_new_used", snap[5], pk(50, 51, 1051, 52));

    // Reset asserted in the middle of CALC.
    v_in = pk(0, 0, 0, 1600); chan_en = 4'hF; step = 1'b1;
    @(posedge clk); #1; step = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_vout", v_out, 64'h0);
    chk("midrst_ctl", {60'h0, busy, done, overrun, |sat_flag}, 64'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle", {62'h0, busy, done}, 64'h0);
    run_step(pk(0, 0, 0, 1600), 4'hF, 6'b0, 0, 2'd0, 16'h0);
    chk("rst_coef_default", snap[5], pk(0, 0, 0, 100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
